// File: rtl/ecg_beat_detector.sv
// ecg_beat_detector: threshold/peak-tracking QRS detector with refractory blanking.
// Optional macro ECG_TIMEOUT_DECAY_EN halves max after TIMEOUT beatless samples.
module ecg_beat_detector #(
   parameter int DATA_WIDTH = 16,
   parameter int INIT_MAX   = 100,
   parameter int MIN_MAX    = 8,
   parameter int REFRACT    = 72,
   parameter int TIMEOUT    = 420,
   parameter int CNT_W      = 12
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         en,
   input  logic signed [DATA_WIDTH-1:0] xin,
   input  logic                         xin_valid,
   output logic                         qrs,
   output logic signed [DATA_WIDTH-1:0] max,
   output logic        [CNT_W-1:0]      rr
);
   typedef enum logic [1:0] {SEARCH, TRACK, BLANK} state_t;
   localparam logic signed [DATA_WIDTH-1:0] INIT_V = DATA_WIDTH'(INIT_MAX);
   state_t                         state, state_n;
   logic signed [DATA_WIDTH-1:0]   peakf, peakf_n, max_n, thr, pk;
   logic        [CNT_W-1:0]        since_cnt, since_n, since_inc, blank_cnt, blank_n, rr_n;
   logic                           acc, beat;
`ifdef ECG_TIMEOUT_DECAY_EN
   localparam logic signed [DATA_WIDTH-1:0] MIN_V = DATA_WIDTH'(MIN_MAX);
   logic signed [DATA_WIDTH-1:0]   half;
   assign half = max >>> 1;
`endif
   assign thr       = max >>> 1;
   assign acc       = en && xin_valid;
   assign since_inc = (since_cnt == '1) ? since_cnt : since_cnt + CNT_W'(1);
   assign pk        = (xin > peakf) ? xin : peakf;
   always_comb begin
      state_n = state;
      peakf_n = peakf;
      max_n   = max;
      rr_n    = rr;
      since_n = since_cnt;
      blank_n = blank_cnt;
      beat    = 1'b0;
      if (acc) begin
         since_n = since_inc;
         case (state)
            SEARCH: begin
               if (xin > thr) begin
                  state_n = TRACK;
                  peakf_n = xin;
               end
`ifdef ECG_TIMEOUT_DECAY_EN
               else if (since_cnt >= CNT_W'(TIMEOUT - 1)) begin
                  max_n   = (half < MIN_V) ? MIN_V : half;
                  since_n = '0;
               end
`endif
            end
            TRACK: begin
               peakf_n = pk;
               if (xin < thr) begin
                  beat    = 1'b1;
                  max_n   = pk;
                  rr_n    = since_inc;
                  since_n = '0;
                  blank_n = '0;
                  state_n = BLANK;
               end
            end
            BLANK: begin
               blank_n = blank_cnt + CNT_W'(1);
               state_n = (blank_n >= CNT_W'(REFRACT - 1)) ? SEARCH : BLANK;
            end
            default: state_n = SEARCH;
         endcase
      end
   end
   // qrs follows beat every edge so it can never stretch while en is low
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= SEARCH;
         qrs       <= 1'b0;
         max       <= INIT_V;
         rr        <= '0;
         peakf     <= '0;
         since_cnt <= '0;
         blank_cnt <= '0;
      end else begin
         state     <= state_n;
         qrs       <= beat;
         max       <= max_n;
         rr        <= rr_n;
         peakf     <= peakf_n;
         since_cnt <= since_n;
         blank_cnt <= blank_n;
      end
   end
endmodule

// File: tb/tb_ecg_beat_detector.sv
// tb_ecg_beat_detector: directed vectors with a beat scoreboard drained by a qrs monitor.
module tb_ecg_beat_detector;
   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic               en = 1'b1;
   logic               xin_valid = 1'b0;
   logic signed [15:0] xin = '0;
   logic               qrs;
   logic signed [15:0] max;
   logic [11:0]        rr;
   int                 total = 0;
   int                 bad = 0;
   logic signed [15:0] exp_max[$];
   int                 exp_rr[$];

   ecg_beat_detector dut (
      .clk(clk), .rstn(rstn), .en(en), .xin(xin), .xin_valid(xin_valid),
      .qrs(qrs), .max(max), .rr(rr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic expect_beat(input int m, input int r);
      exp_max.push_back(16'(m));
      exp_rr.push_back(r);
   endtask

   task automatic send(input int x);
      en = 1'b1;
      xin_valid = 1'b1;
      xin = 16'(x);
      @(negedge clk);
   endtask

   task automatic zeros(input int n);
      for (int i = 0; i < n; i++) send(0);
   endtask

   // a non-accepted cycle; with en low, qrs must stay low
   task automatic gap(input bit e, input bit v, input int x);
      en = e;
      xin_valid = v;
      xin = 16'(x);
      @(negedge clk);
      if (!e) check("qrs_en_low", int'(qrs), 0);
   endtask

   always @(negedge clk) begin
      if (rstn && qrs) begin
         if (exp_max.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_qrs: got qrs=1 expected no beat (max=%0d rr=%0d)", max, rr);
         end else begin
            check("beat_max", int'(max), int'(exp_max.pop_front()));
            check("beat_rr", int'(rr), exp_rr.pop_front());
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_qrs", int'(qrs), 0);
      check("rst_max", int'(max), 100);
      check("rst_rr", int'(rr), 0);
      rstn = 1'b1;
`ifdef ECG_TIMEOUT_DECAY_EN
      zeros(420);
      check("decay1", int'(max), 50);
      zeros(420);
      check("decay2", int'(max), 25);
      zeros(420);
      check("decay3", int'(max), 12);
      zeros(420);
      check("decay_clamp", int'(max), 8);
      zeros(420);
      check("decay_clamp2", int'(max), 8);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
`endif
      // first beat: rr counts accepted samples since reset
      send(0); send(0); send(60); send(90);
      expect_beat(90, 5);
      send(40);
      send(0);
      // blanking: 200s inside the refractory window are ignored
      for (int i = 0; i < 70; i++) send(200);
      send(200);
      expect_beat(200, 73);
      send(0);
      // periodic beats
      for (int p = 0; p < 3; p++) begin
         zeros(208);
         send(120);
         expect_beat(120, 210);
         send(0);
      end
      // valid/en gaps must not change counts or peaks
      zeros(100);
      repeat (3) gap(1'b1, 1'b0, 120);
      repeat (3) gap(1'b0, 1'b1, 120);
      zeros(108);
      send(120);
      gap(1'b1, 1'b0, 0);
      gap(1'b0, 1'b1, 0);
      gap(1'b1, 1'b0, 300);
      gap(1'b0, 1'b1, 300);
      expect_beat(120, 210);
      send(0);
      check("qrs_one_cycle", int'(qrs), 1);
      send(0);
      check("qrs_cleared", int'(qrs), 0);
      // reset mid-TRACK discards the pending beat
      zeros(207);
      send(90);
      rstn = 1'b0;
      xin_valid = 1'b0;
      @(negedge clk);
      check("midrst_qrs", int'(qrs), 0);
      check("midrst_max", int'(max), 100);
      check("midrst_rr", int'(rr), 0);
      rstn = 1'b1;
      zeros(3);
      check("post_rst_max", int'(max), 100);
      send(60); send(90);
      expect_beat(90, 6);
      send(40);
      send(0);
`ifndef ECG_TIMEOUT_DECAY_EN
      // long silence: max holds, since counter saturates
      zeros(4100);
      check("no_decay_max", int'(max), 90);
      send(60);
      expect_beat(60, 4095);
      send(0);
`endif
      zeros(4);
      check("scoreboard_empty", exp_max.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
